stream_aligner: RTL and testbench
=================================

STREAM_ALIGNER -- requirements
Module: stream_aligner

Interface
REQ-001 SHALL have parameter element_width, default 64, giving the data width of each lane.
REQ-002 SHALL have parameter depth, default 8, giving the per-lane buffer depth; it is a power of two from 2 to 16.
REQ-003 SHALL have parameter cnt_width, default 4, equal to log2(depth)+1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-006 SHALL have port a_in, input, element_width bits: lane A element, e.g. the short path.
REQ-007 SHALL have port a_valid, input, 1 bit: a_in is presented this cycle.
REQ-008 SHALL have port b_in, input, element_width bits: lane B element, e.g. the path through a fixed-latency delay line.
REQ-009 SHALL have port b_valid, input, 1 bit: b_in is presented this cycle.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts a pair this cycle.
REQ-011 SHALL have port a_out, output, element_width bits: head of lane A.
REQ-012 SHALL have port b_out, output, element_width bits: head of lane B.
REQ-013 SHALL have port out_valid, output, 1 bit: an aligned pair is available.
REQ-014 SHALL have ports a_count and b_count, output, cnt_width bits each: lane occupancy.
REQ-015 SHALL have ports a_full and b_full, output, 1 bit each: the lane count equals depth.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag for a dropped write.

Function
REQ-017 SHALL buffer each lane in an independent circular FIFO with write pointer, read pointer and count; pointers wrap from depth-1 to 0.
REQ-018 SHALL drive out_valid = (a_count != 0) AND (b_count != 0), combinationally from registered state.
REQ-019 SHALL drive a_out and b_out with the lane heads when out_valid=1, and with all zeros when out_valid=0.
REQ-020 SHALL pop both lanes together in any cycle where out_valid AND out_ready; it SHALL never pop only one lane.
REQ-021 SHALL accept a lane write when valid=1 and either count<depth or a pop occurs in the same cycle.
REQ-022 SHALL make a written element visible at the outputs no earlier than the cycle after the write (1-cycle minimum latency, no bypass).
REQ-023 SHALL update each lane count as count + write - pop; a simultaneous write and pop leaves the count unchanged and advances both pointers.
REQ-024 SHALL drop a write to a full lane with no same-cycle pop, leave that lane's state unchanged, and set overflow on the next edge.
REQ-025 SHALL hold overflow at 1 until reset; the other lane continues to operate normally.
REQ-026 SHALL preserve per-lane order, so the k-th accepted A element is always paired with the k-th accepted B element.
REQ-027 SHALL hold outputs stable while out_valid=1 and out_ready=0.
REQ-028 SHALL ignore out_ready when out_valid=0.

Reset
REQ-029 SHALL, while reset=1 at an edge, clear all pointers, counts and overflow; a_full, b_full and out_valid go to 0, and a_out and b_out read as 0 from the next cycle.
REQ-030 SHALL give reset priority over simultaneous writes and pops; inputs in a reset cycle are discarded, including data in flight when reset arrives mid-operation.
REQ-031 SHALL not require clearing of the storage array; stale contents are never visible because counts are 0.

Verification
REQ-032 SHALL pass a skew test: write A=0x11,0x22,0x33 on cycles 1-3, then B=0xA1,0xA2,0xA3 on cycles 5-7, with out_ready=1 -> pairs (0x11,0xA1), (0x22,0xA2), (0x33,0xA3) appear on cycles 6-8, and a_count peaks at 3.
REQ-033 SHALL pass a backpressure test: hold out_ready=0 with both lanes holding 2 elements -> outputs stable and counts stay 2; raise out_ready for 2 cycles -> both lanes empty and out_valid=0.
REQ-034 SHALL pass an overflow test: depth=8, write 9 A elements with no B -> a_full=1 after the 8th write, the 9th is dropped, overflow=1 thereafter, and later B writes pair with A elements 1-8 only.
REQ-035 SHALL pass a full-with-pop test: A full, B count 1, out_ready=1 and a_valid=1 in the same cycle -> the write is accepted, a_count stays 8, b_count goes to 0, and overflow stays 0.
REQ-036 SHALL pass a wrap test: stream 20 pairs continuously with out_ready=1 -> all pairs in order, with pointers wrapping twice.
REQ-037 SHALL pass a reset-mid-stream test: assert reset with counts 3 and 5 while a_valid=1 -> next cycle counts are 0, out_valid=0, overflow=0, and the first post-reset pair is the first post-reset writes.

Source files
------------

// File: rtl/stream_aligner.sv
// Pairs two independently delayed element streams: one circular FIFO per lane, both popped together.
// Latency 1 cycle write-to-head (no bypass); a full lane drops writes unless popped that cycle, setting sticky overflow.

module stream_aligner_lane #(
    parameter int element_width = 64,
    parameter int depth         = 8,
    parameter int cnt_width     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [element_width-1:0] data,
    input  logic                     valid,
    input  logic                     pop,
    output logic [element_width-1:0] head,
    output logic [cnt_width-1:0]     count,
    output logic                     full,
    output logic                     drop
);
    localparam int ptr_width = cnt_width - 1;

    logic [element_width-1:0] mem [depth];
    logic [ptr_width-1:0]     wr_ptr;
    logic [ptr_width-1:0]     rd_ptr;
    logic                     wr_en;

    assign full  = (count == cnt_width'(depth));
    // A pop in the same cycle frees the slot the write needs.
    assign wr_en = valid && (!full || pop);
    assign drop  = valid && !wr_en;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ptr_width'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_width'(1);
            end
            count <= count + cnt_width'(wr_en) - cnt_width'(pop);
        end
    end

    // Storage is never cleared; a zero count hides stale entries.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_ptr] <= data;
        end
    end
endmodule

module stream_aligner #(
    parameter int element_width = 64,
    parameter int depth         = 8,
    parameter int cnt_width     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [element_width-1:0] a_in,
    input  logic                     a_valid,
    input  logic [element_width-1:0] b_in,
    input  logic                     b_valid,
    input  logic                     out_ready,
    output logic [element_width-1:0] a_out,
    output logic [element_width-1:0] b_out,
    output logic                     out_valid,
    output logic [cnt_width-1:0]     a_count,
    output logic [cnt_width-1:0]     b_count,
    output logic                     a_full,
    output logic                     b_full,
    output logic                     overflow
);
    logic [element_width-1:0] a_head;
    logic [element_width-1:0] b_head;
    logic                     a_drop;
    logic                     b_drop;
    logic                     pop;

    assign out_valid = (a_count != '0) && (b_count != '0);
    assign pop       = out_valid && out_ready;
    assign a_out     = out_valid ? a_head : '0;
    assign b_out     = out_valid ? b_head : '0;

    stream_aligner_lane #(
        .element_width(element_width),
        .depth(depth),
        .cnt_width(cnt_width)
    ) u_lane_a (
        .clk(clk),
        .reset(reset),
        .data(a_in),
        .valid(a_valid),
        .pop(pop),
        .head(a_head),
        .count(a_count),
        .full(a_full),
        .drop(a_drop)
    );

    stream_aligner_lane #(
        .element_width(element_width),
        .depth(depth),
        .cnt_width(cnt_width)
    ) u_lane_b (
        .clk(clk),
        .reset(reset),
        .data(b_in),
        .valid(b_valid),
        .pop(pop),
        .head(b_head),
        .count(b_count),
        .full(b_full),
        .drop(b_drop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (a_drop || b_drop) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stream_aligner.sv
// Bench for stream_aligner: queue-based reference model checked every cycle, a skew vector table,
// and hand-written backpressure, overflow, full-with-pop, wrap and mid-stream reset sequences.
module tb_stream_aligner;
    localparam int W  = 64;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  a_in, b_in;
    logic          a_valid, b_valid, out_ready;
    logic [W-1:0]  a_out, b_out;
    logic          out_valid;
    logic [CW-1:0] a_count, b_count;
    logic          a_full, b_full, overflow;

    stream_aligner #(.element_width(W), .depth(D), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset),
        .a_in(a_in), .a_valid(a_valid),
        .b_in(b_in), .b_valid(b_valid),
        .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
        .a_count(a_count), .b_count(b_count),
        .a_full(a_full), .b_full(b_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_pairs = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    bit ovf_m = 1'b0;

    typedef struct {
        bit         av;
        logic [W-1:0] a;
        bit         bv;
        logic [W-1:0] b;
        bit         rdy;
        bit         e_ov;
        logic [W-1:0] e_a;
        logic [W-1:0] e_b;
        int         e_ac;
        int         e_bc;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, then at the falling edge compare outputs with the model.
    task automatic step_begin(input bit rst, input bit av, input logic [W-1:0] ad,
                              input bit bv, input logic [W-1:0] bd, input bit rdy);
        logic [W-1:0] ea, eb;
        bit eov;
        reset = rst; a_valid = av; a_in = ad; b_valid = bv; b_in = bd; out_ready = rdy;
        @(negedge clk);
        eov = (qa.size() != 0) && (qb.size() != 0);
        ea = '0;
        eb = '0;
        if (eov) begin
            ea = qa[0];
            eb = qb[0];
        end
        chk("out_valid", W'(out_valid), W'(eov));
        chk("a_out", a_out, ea);
        chk("b_out", b_out, eb);
        chk("a_count", W'(a_count), W'(qa.size()));
        chk("b_count", W'(b_count), W'(qb.size()));
        chk("a_full", W'(a_full), W'(qa.size() == D));
        chk("b_full", W'(b_full), W'(qb.size() == D));
        chk("overflow", W'(overflow), W'(ovf_m));
        if (out_valid && out_ready) dut_pairs++;
    endtask

    // Clock edge, then advance the model with the inputs applied in this cycle.
    task automatic step_end();
        bit pop;
        int na, nb;
        @(posedge clk);
        #1;
        if (reset) begin
            qa.delete();
            qb.delete();
            ovf_m = 1'b0;
        end else begin
            na = qa.size();
            nb = qb.size();
            pop = (na != 0) && (nb != 0) && out_ready;
            if (pop) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (a_valid) begin
                if (na < D || pop) qa.push_back(a_in);
                else ovf_m = 1'b1;
            end
            if (b_valid) begin
                if (nb < D || pop) qb.push_back(b_in);
                else ovf_m = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit av, input logic [W-1:0] ad,
                       input bit bv, input logic [W-1:0] bd, input bit rdy);
        step_begin(rst, av, ad, bv, bd, rdy);
        step_end();
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        // Skew: A on cycles 1-3, B on cycles 5-7; pairs appear on cycles 6-8.
        tbl[0] = '{1'b1, 64'h11, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  64'h0,  0, 0};
        tbl[1] = '{1'b1, 64'h22, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  64'h0,  1, 0};
        tbl[2] = '{1'b1, 64'h33, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  64'h0,  2, 0};
        tbl[3] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  64'h0,  3, 0};
        tbl[4] = '{1'b0, 64'h0,  1'b1, 64'hA1, 1'b1, 1'b0, 64'h0,  64'h0,  3, 0};
        tbl[5] = '{1'b0, 64'h0,  1'b1, 64'hA2, 1'b1, 1'b1, 64'h11, 64'hA1, 3, 1};
        tbl[6] = '{1'b0, 64'h0,  1'b1, 64'hA3, 1'b1, 1'b1, 64'h22, 64'hA2, 2, 1};
        tbl[7] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 1'b1, 64'h33, 64'hA3, 1, 1};
        tbl[8] = '{1'b0, 64'h0,  1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  64'h0,  0, 0};

        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with out_ready high to show it is ignored when empty.
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 9; i++) begin
            step_begin(1'b0, tbl[i].av, tbl[i].a, tbl[i].bv, tbl[i].b, tbl[i].rdy);
            chk("skew_valid", W'(out_valid), W'(tbl[i].e_ov));
            chk("skew_a_out", a_out, tbl[i].e_a);
            chk("skew_b_out", b_out, tbl[i].e_b);
            chk("skew_a_count", W'(a_count), W'(tbl[i].e_ac));
            chk("skew_b_count", W'(b_count), W'(tbl[i].e_bc));
            step_end();
        end

        // Backpressure: two pairs held, then drained in two cycles.
        do_reset();
        cyc(1'b0, 1'b1, 64'h51, 1'b1, 64'h61, 1'b0);
        cyc(1'b0, 1'b1, 64'h52, 1'b1, 64'h62, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step_begin(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
            chk("bp_a_out_hold", a_out, 64'h51);
            chk("bp_b_out_hold", b_out, 64'h61);
            chk("bp_counts", W'({a_count, b_count}), W'({4'd2, 4'd2}));
            step_end();
        end
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        step_begin(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("bp_drained_valid", W'(out_valid), 64'h0);
        chk("bp_drained_counts", W'({a_count, b_count}), 64'h0);
        step_end();

        // Overflow: 9 A writes into depth 8, then 8 B writes pair with A 1-8.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 1'b1, W'(64'h100 + i), 1'b0, '0, 1'b1);
            if (i == 8) chk("ovf_full_after_8", W'(a_full), 64'h1);
        end
        chk("ovf_flag", W'(overflow), 64'h1);
        chk("ovf_count", W'(a_count), 64'h8);
        for (int i = 1; i <= 8; i++) begin
            step_begin(1'b0, 1'b0, '0, 1'b1, W'(64'h200 + i), 1'b1);
            if (i > 1) chk("ovf_pair_a", a_out, W'(64'h100 + i - 1));
            step_end();
        end
        step_begin(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("ovf_last_pair", a_out, 64'h108);
        step_end();
        step_begin(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("ovf_drained", W'({a_count, b_count, out_valid}), 64'h0);
        chk("ovf_sticky", W'(overflow), 64'h1);
        step_end();

        // Full with pop: A full, B holds one, write A while popping.
        do_reset();
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, 1'b1, W'(64'h300 + i), (i == 0), 64'h400, 1'b0);
        end
        cyc(1'b0, 1'b1, 64'h3FF, 1'b0, '0, 1'b1);
        step_begin(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("fwp_a_count", W'(a_count), 64'h8);
        chk("fwp_b_count", W'(b_count), 64'h0);
        chk("fwp_overflow", W'(overflow), 64'h0);
        step_end();

        // Wrap: 20 continuous pairs through a depth-8 lane.
        do_reset();
        dut_pairs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, W'(64'h500 + i), 1'b1, W'(64'h600 + i), 1'b1);
        end
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("wrap_pairs", W'(dut_pairs), 64'd20);

        // Reset mid-stream with counts 3 and 5 and a write in flight.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, (i < 3), W'(64'h700 + i), 1'b1, W'(64'h800 + i), 1'b0);
        end
        step_begin(1'b1, 1'b1, 64'h7FF, 1'b1, 64'h8FF, 1'b1);
        chk("rst_pre_counts", W'({a_count, b_count}), W'({4'd3, 4'd5}));
        step_end();
        step_begin(1'b0, 1'b1, 64'h77, 1'b1, 64'h88, 1'b1);
        chk("rst_counts", W'({a_count, b_count}), 64'h0);
        chk("rst_valid_ovf", W'({out_valid, overflow}), 64'h0);
        step_end();
        step_begin(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("rst_first_pair", W'({a_out[15:0], b_out[15:0]}), 64'h0077_0088);
        step_end();
        cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
